// File: rtl/comp_pkg.sv
// Shared definitions for the sequential magnitude comparator.
//   state_t      : controller states (IDLE, COMPARE, DONE)
//   RES_*        : result encoding, one-hot in {C1, C2, C3} order
//   num_chunks() : number of CHUNK-bit slices in a WIDTH-bit operand
package comp_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPARE = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic [2:0] RES_NONE = 3'b000;
   localparam logic [2:0] RES_GT   = 3'b100;
   localparam logic [2:0] RES_EQ   = 3'b010;
   localparam logic [2:0] RES_LT   = 3'b001;

   function automatic int num_chunks(input int width, input int chunk);
      return width / chunk;
   endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-bit slice.
// Ports:
//   a, b : slice operands
//   gt   : a > b
//   lt   : a < b
module chunk_cmp #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   output logic             gt,
   output logic             lt
);

   assign gt = (a > b);
   assign lt = (a < b);

endmodule

// File: rtl/seq_mag_comp.sv
// Multi-cycle magnitude comparator: compares A and B CHUNK bits per cycle,
// most-significant chunk first, signed or unsigned.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : request a compare (accepted only in IDLE)
//   A, B, signed_mode : operands and mode, captured on accepted start
//   busy              : high in COMPARE and DONE
//   done              : one-cycle pulse when C1/C2/C3 are valid
//   C1 / C2 / C3      : A > B / A == B / A < B (held until next start)
// Build option: define SEQ_MAG_COMP_EARLY_EXIT_EN to leave COMPARE on the
// first differing chunk; otherwise every chunk is scanned (fixed latency).
//
// state   | meaning
// IDLE    | waiting for start, previous result held on C1/C2/C3
// COMPARE | one chunk compared per cycle, index counting down
// DONE    | result valid, done pulse
module seq_mag_comp
   import comp_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             signed_mode,
   output logic             busy,
   output logic             done,
   output logic             C1,
   output logic             C2,
   output logic             C3
);

   localparam int NC    = num_chunks(WIDTH, CHUNK);
   localparam int IDX_W = (NC > 1) ? $clog2(NC) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NC - 1);

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic               sm_q, sm_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [2:0]         dec_q, dec_d;
   logic [2:0]         res_q, res_d;

   logic [CHUNK-1:0]   a_chunk, b_chunk, a_cmp, b_cmp;
   logic               chunk_gt, chunk_lt;
   logic [2:0]         cur_dec;
   logic               exit_cmp;

   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int i = 0; i < NC; i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_chunk = a_q[i*CHUNK +: CHUNK];
            b_chunk = b_q[i*CHUNK +: CHUNK];
         end
      end
      // Flipping the sign bit maps two's-complement order onto unsigned order.
      a_cmp = a_chunk;
      b_cmp = b_chunk;
      if (sm_q && (idx_q == IDX_TOP)) begin
         a_cmp[CHUNK-1] = ~a_chunk[CHUNK-1];
         b_cmp[CHUNK-1] = ~b_chunk[CHUNK-1];
      end
   end

   chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
      .a  (a_cmp),
      .b  (b_cmp),
      .gt (chunk_gt),
      .lt (chunk_lt)
   );

   // A recorded decision is sticky; later chunks cannot override it.
   always_comb begin
      if (dec_q != RES_NONE)   cur_dec = dec_q;
      else if (chunk_gt)       cur_dec = RES_GT;
      else if (chunk_lt)       cur_dec = RES_LT;
      else if (idx_q == '0)    cur_dec = RES_EQ;
      else                     cur_dec = RES_NONE;
   end

`ifdef SEQ_MAG_COMP_EARLY_EXIT_EN
   assign exit_cmp = (cur_dec != RES_NONE);
`else
   assign exit_cmp = (idx_q == '0);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sm_q    <= 1'b0;
         idx_q   <= '0;
         dec_q   <= RES_NONE;
         res_q   <= RES_NONE;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sm_q    <= sm_d;
         idx_q   <= idx_d;
         dec_q   <= dec_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sm_d    = sm_q;
      idx_d   = idx_q;
      dec_d   = dec_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               sm_d    = signed_mode;
               idx_d   = IDX_TOP;
               dec_d   = RES_NONE;
               res_d   = RES_NONE;
               state_d = COMPARE;
            end
         end
         COMPARE: begin
            dec_d = cur_dec;
            if (idx_q != '0) idx_d = idx_q - IDX_W'(1);
            if (exit_cmp) begin
               res_d   = cur_dec;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
   end

   assign C1 = res_q[2];
   assign C2 = res_q[1];
   assign C3 = res_q[0];

endmodule

// File: tb/tb_seq_mag_comp.sv
module tb_seq_mag_comp;

   localparam int WIDTH = 16;
   localparam int CHUNK = 4;
   localparam int NC    = WIDTH / CHUNK;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] A, B;
   logic             signed_mode;
   logic             busy, done, C1, C2, C3;

   typedef struct {
      logic [2:0] flags;
      int         lat;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   seq_mag_comp #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .A           (A),
      .B           (B),
      .signed_mode (signed_mode),
      .busy        (busy),
      .done        (done),
      .C1          (C1),
      .C2          (C2),
      .C3          (C3)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic sm);
      exp_t e;
      int   k;
      if (sm) begin
         if ($signed(a) > $signed(b))      e.flags = 3'b100;
         else if ($signed(a) < $signed(b)) e.flags = 3'b001;
         else                              e.flags = 3'b010;
      end else begin
         if (a > b)      e.flags = 3'b100;
         else if (a < b) e.flags = 3'b001;
         else            e.flags = 3'b010;
      end
      k = NC;
      for (int i = 0; i < NC; i++)
         if (k == NC && a[WIDTH-1-i*CHUNK -: CHUNK] != b[WIDTH-1-i*CHUNK -: CHUNK]) k = i;
`ifdef SEQ_MAG_COMP_EARLY_EXIT_EN
      e.lat = (k == NC) ? NC + 1 : k + 2;
`else
      e.lat = NC + 1;
`endif
      return e;
   endfunction

   // Drive one start for a single edge and push its expected result.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic sm);
      @(negedge clk);
      A = a; B = b; signed_mode = sm; start = 1'b1;
      sb.push_back(model(a, b, sm));
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Wait (bounded) for done; j0 = cycles already elapsed since the start edge.
   task automatic wait_done(input int j0, output int lat, output bit quiet_ok);
      lat = -1;
      quiet_ok = 1'b1;
      for (int j = j0 + 1; j <= NC + 6; j++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = j;
            break;
         end
         if (busy !== 1'b1 || {C1, C2, C3} !== 3'b000) quiet_ok = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; A = 16'hFFFF; B = 16'h0000; signed_mode = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({busy, done, C1, C2, C3} !== 5'b0) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 00000", {busy, done, C1, C2, C3});
      end
      start = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({busy, done, C1, C2, C3} !== 5'b0) begin
         bad++;
         $display("FAIL reset_idle: got %b want 00000", {busy, done, C1, C2, C3});
      end
   endtask

   task automatic test_vectors();
      logic [WIDTH-1:0] ta[6] = '{16'hC000, 16'h5A5A, 16'h0002, 16'h8000, 16'h8000, 16'h5A5A};
      logic [WIDTH-1:0] tb[6] = '{16'hA000, 16'h5A5A, 16'h0C00, 16'h0001, 16'h0001, 16'h5A5A};
      logic             ts[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [WIDTH-1:0] a, b;
      logic             sm;
      exp_t e;
      int   lat;
      bit   q;
      for (int n = 0; n < 18; n++) begin
         if (n < 6) begin
            a = ta[n]; b = tb[n]; sm = ts[n];
         end else begin
            a = 16'($urandom);
            b = 16'($urandom);
            // share a random number of top chunks to spread the deciding position
            if (n % 3 != 0) b[WIDTH-1 -: CHUNK*2] = a[WIDTH-1 -: CHUNK*2];
            if (n % 4 == 0) b[WIDTH-1 -: CHUNK] = a[WIDTH-1 -: CHUNK];
            sm = 1'($urandom);
         end
         issue(a, b, sm);
         wait_done(0, lat, q);
         e = sb.pop_front();
         total++;
         if (lat !== e.lat) begin
            bad++;
            $display("FAIL vec_latency[%0d] A=%h B=%h s=%b: got %0d want %0d", n, a, b, sm, lat, e.lat);
         end
         total++;
         if ({C1, C2, C3} !== e.flags) begin
            bad++;
            $display("FAIL vec_result[%0d] A=%h B=%h s=%b: got %b want %b", n, a, b, sm, {C1, C2, C3}, e.flags);
         end
         total++;
         if (!q) begin
            bad++;
            $display("FAIL vec_busy_flags[%0d]: got busy/flags wrong while comparing want busy=1 flags=000", n);
         end
         @(negedge clk);
         total++;
         if (done !== 1'b0 || busy !== 1'b0 || {C1, C2, C3} !== e.flags) begin
            bad++;
            $display("FAIL vec_hold[%0d]: got done=%b busy=%b flags=%b want 0 0 %b",
                     n, done, busy, {C1, C2, C3}, e.flags);
         end
      end
   endtask

   task automatic test_ignore_start();
      exp_t e;
      int   lat;
      bit   q;
      bit   extra;
      issue(16'h1234, 16'h1235, 1'b0);
      @(negedge clk);
      @(negedge clk);
      A = 16'hFFFF; B = 16'h0000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(2, lat, q);
      e = sb.pop_front();
      total++;
      if (lat !== e.lat) begin
         bad++;
         $display("FAIL ignore_latency: got %0d want %0d", lat, e.lat);
      end
      total++;
      if ({C1, C2, C3} !== 3'b001) begin
         bad++;
         $display("FAIL ignore_result: got %b want 001", {C1, C2, C3});
      end
      extra = 1'b0;
      repeat (NC + 3) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) extra = 1'b1;
      end
      total++;
      if (extra) begin
         bad++;
         $display("FAIL ignore_no_second_run: got extra busy/done want none");
      end
   endtask

   task automatic test_abort();
      exp_t e;
      int   lat;
      bit   q;
      bit   extra;
      issue(16'h0F0F, 16'h0F0E, 1'b0);
      void'(sb.pop_front());
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({busy, done, C1, C2, C3} !== 5'b0) begin
         bad++;
         $display("FAIL abort_outputs: got %b want 00000", {busy, done, C1, C2, C3});
      end
      rst = 1'b0;
      extra = 1'b0;
      repeat (NC + 3) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) extra = 1'b1;
      end
      total++;
      if (extra) begin
         bad++;
         $display("FAIL abort_no_done: got busy/done after abort want none");
      end
      issue(16'h7000, 16'h9000, 1'b1);
      wait_done(0, lat, q);
      e = sb.pop_front();
      total++;
      if (lat !== e.lat || {C1, C2, C3} !== e.flags) begin
         bad++;
         $display("FAIL abort_fresh: got lat=%0d flags=%b want lat=%0d flags=%b",
                  lat, {C1, C2, C3}, e.lat, e.flags);
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      int   lat;
      bit   q;
      logic [WIDTH-1:0] a, b;
      issue(16'h0100, 16'h0200, 1'b0);
      wait_done(0, lat, q);
      for (int n = 0; n < 4; n++) begin
         e = sb.pop_front();
         total++;
         if (lat !== e.lat || {C1, C2, C3} !== e.flags || !q) begin
            bad++;
            $display("FAIL b2b_result[%0d]: got lat=%0d flags=%b quiet=%b want lat=%0d flags=%b quiet=1",
                     n, lat, {C1, C2, C3}, q, e.lat, e.flags);
         end
         if (n == 3) break;
         // start raised during DONE must wait for the IDLE cycle
         a = 16'($urandom);
         b = (n == 1) ? a : 16'($urandom);
         A = a; B = b; signed_mode = 1'(n); start = 1'b1;
         sb.push_back(model(a, b, 1'(n)));
         @(negedge clk);
         total++;
         if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle_gap[%0d]: got busy=%b done=%b want 0 0", n, busy, done);
         end
         @(posedge clk);
         #1 start = 1'b0;
         wait_done(0, lat, q);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; A = '0; B = '0; signed_mode = 1'b0;
      test_reset();
      test_vectors();
      test_ignore_start();
      test_abort();
      test_back_to_back();
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_mag_comp.md
# seq_mag_comp

Parametrised, multi-cycle magnitude comparator. It is the successor to the 4-bit combinational comparator, extended to any operand width, signed or unsigned operands, and a start/done handshake. It compares CHUNK bits per cycle, most-significant chunk first, and reports greater/equal/less on the C1/C2/C3 flags. It sits in the ALU datapath as the compare unit behind the operand registers.

## Interface
Parameters:
- WIDTH, default 16: operand width in bits. Must satisfy WIDTH ≥ CHUNK and WIDTH % CHUNK == 0.
- CHUNK, default 4: bits compared per cycle. NUM_CHUNKS = WIDTH/CHUNK.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a compare; sampled only in IDLE.
- A  in  WIDTH  operand A; captured when start is accepted.
- B  in  WIDTH  operand B; captured when start is accepted.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with A and B.
- busy  out  1  high in COMPARE and DONE.
- done  out  1  single-cycle pulse; result is valid.
- C1  out  1  A > B.
- C2  out  1  A == B.
- C3  out  1  A < B.

## Operation
- States: IDLE, COMPARE, DONE.
- IDLE: start=1 latches A, B and signed_mode. It also clears C1/C2/C3 to 0, loads the chunk index to NUM_CHUNKS-1, and moves to COMPARE.
- COMPARE: each cycle compares A_reg and B_reg at the current chunk (unsigned compare), then decrements the index.
  - Signed mode: in the top chunk only, invert the MSB of both operands before comparing.
  - First differing chunk: record gt or lt. Later chunks never overwrite a recorded decision.
  - Index 0 with no difference recorded: record eq.
  - Leave COMPARE when a decision is made (see Configuration for when that is).
- DONE: done=1 for exactly one cycle, then return to IDLE.
- C1/C2/C3 are registered. They are held from done until the next accepted start.
- After done, exactly one of C1/C2/C3 is 1. While busy, all three are 0.
- start is ignored in COMPARE and DONE. New operands during that time do not affect the in-flight result.
- Reset, including mid-operation: state goes to IDLE, busy=done=C1=C2=C3=0, and the operand registers clear. No done is issued for the aborted compare.
- Reset value of every output is 0.

## Timing
- start is sampled at edge T. COMPARE occupies cycles T+1 onward, one chunk per cycle.
- Full scan: done is high in cycle T+NUM_CHUNKS+1. With defaults this is T+5.
- Early exit: if chunk position k (k=0 is the MSB chunk) decides, done is high in cycle T+k+2.
- Equal operands always take the full scan.
- C1/C2/C3 update on the same edge on which done rises.
- Back-to-back throughput: a new start can be accepted at the earliest one cycle after done, i.e. the first IDLE cycle.

## Configuration
- SEQ_MAG_COMP_EARLY_EXIT_EN defined: COMPARE exits to DONE on the first differing chunk. Latency depends on the data.
- Undefined: COMPARE always scans all NUM_CHUNKS chunks before DONE, giving fixed latency of NUM_CHUNKS+1 cycles from start to done.
- Results are identical in both builds.

## Structure
- Shared package comp_pkg holds:
  - the state enum typedef (IDLE, COMPARE, DONE);
  - the result encoding localparams (RES_GT, RES_EQ, RES_LT);
  - the NUM_CHUNKS derivation helper.
- One sub-module, chunk_cmp: a combinational CHUNK-bit unsigned compare with outputs gt and lt. It is instantiated once and fed by a mux on the chunk index.

## Test plan
Defaults: WIDTH=16, CHUNK=4.
1. signed_mode=0, A=0xC000, B=0xA000 → C1=1, C2=0, C3=0; done at T+2 (early exit) or T+5 (full scan).
2. A=B=0x5A5A, either mode → C2=1 only; done at T+5 in both builds.
3. signed_mode=0, A=0x0002, B=0x0C00 → C3=1; done at T+3 (early exit, k=1) or T+5.
4. A=0x8000, B=0x0001: signed_mode=1 → C3=1; signed_mode=0 → C1=1.
5. Start with A=0x1234, B=0x1235, then assert start with A=0xFFFF at T+2 → second start ignored; result is C3=1 for the first pair.
6. Assert rst at T+2 of a compare → busy=0 next cycle, no done, outputs 0; a fresh start then completes normally.
